// File: rtl/fft_frame_ctrl_if.sv
// Signal bundle between fft_frame_ctrl (master) and its surroundings:
// upstream stream, SDF stage-chain input/output, result stream and status.
interface fft_frame_ctrl_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOG_N = 8
);
    logic             enable;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;
    logic             fft_en;
    logic             fft_on;
    logic [WIDTH-1:0] fft_re;
    logic [WIDTH-1:0] fft_im;
    logic             fft_do_en;
    logic [WIDTH-1:0] fft_do_re;
    logic [WIDTH-1:0] fft_do_im;
    logic             m_valid;
    logic [WIDTH-1:0] m_re;
    logic [WIDTH-1:0] m_im;
    logic             m_sof;
    logic             m_eof;
    logic [LOG_N-1:0] m_index;
    logic             busy;
    logic             underrun;
    logic [15:0]      frame_cnt;

    modport master (
        input  enable, s_valid, s_re, s_im, fft_do_en, fft_do_re, fft_do_im,
        output s_ready, fft_en, fft_on, fft_re, fft_im,
               m_valid, m_re, m_im, m_sof, m_eof, m_index, busy, underrun, frame_cnt
    );

    modport slave (
        output enable, s_valid, s_re, s_im, fft_do_en, fft_do_re, fft_do_im,
        input  s_ready, fft_en, fft_on, fft_re, fft_im,
               m_valid, m_re, m_im, m_sof, m_eof, m_index, busy, underrun, frame_cnt
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer feeding gap-free N-sample bursts into an SDF FFT chain and tagging its output.
// Define FFT_CTRL_ZPAD_EN to zero-fill underrun slots; otherwise an underrun aborts and flushes.
module fft_frame_ctrl #(
    parameter int unsigned N       = 256,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 520
) (
    input logic              clk,
    input logic              rst_n,
    fft_frame_ctrl_if.master bus
);
    localparam int unsigned LOG_N = $clog2(N);
    localparam int unsigned FW    = $clog2(LATENCY + N);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state, state_nx;
    logic [LOG_N-1:0] in_cnt, in_cnt_nx, out_cnt;
    logic [1:0]       pend;
    logic             accept_idle, run_slot, last_slot, take, abort, frame_done;
    logic             out_fire, out_last, flush_done;
    logic             fft_en_q, fft_on_q, underrun_q;
    logic [WIDTH-1:0] fft_re_q, fft_im_q, m_re_q, m_im_q;
    logic             m_valid_q, m_sof_q, m_eof_q;
    logic [LOG_N-1:0] m_index_q;
    logic [15:0]      frame_cnt_q;

    assign accept_idle = (state == IDLE) && bus.enable && bus.s_valid;
    assign run_slot    = (state == RUN);
    assign last_slot   = run_slot && (&in_cnt);
    assign out_fire    = bus.fft_do_en && (pend != 2'd0) && (state != FLUSH);
    assign out_last    = &out_cnt;

`ifdef FFT_CTRL_ZPAD_EN
    assign take       = run_slot;
    assign abort      = 1'b0;
    assign flush_done = 1'b1;
`else
    logic [FW-1:0] flush_cnt;

    assign take       = run_slot && bus.s_valid;
    assign abort      = run_slot && !bus.s_valid;
    assign flush_done = (flush_cnt == FW'(LATENCY + N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                flush_cnt <= '0;
        else if (state != FLUSH)   flush_cnt <= '0;
        else                       flush_cnt <= flush_cnt + 1'b1;
    end
`endif

    assign frame_done = last_slot && take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            in_cnt <= '0;
        end else begin
            state  <= state_nx;
            in_cnt <= in_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_cnt_nx = in_cnt;
        unique case (state)
            IDLE: begin
                if (accept_idle) begin
                    state_nx  = RUN;
                    in_cnt_nx = LOG_N'(1);
                end
            end
            RUN: begin
                // in_cnt wraps to 0 at N-1 whether the next frame follows or not
                in_cnt_nx = in_cnt + 1'b1;
                if (abort) begin
                    state_nx  = FLUSH;
                    in_cnt_nx = '0;
                end else if (last_slot) begin
                    state_nx = (bus.enable && bus.s_valid) ? RUN : IDLE;
                end
            end
            FLUSH: begin
                in_cnt_nx = '0;
                if (flush_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_en_q   <= 1'b0;
            fft_on_q   <= 1'b0;
            fft_re_q   <= '0;
            fft_im_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            fft_en_q   <= accept_idle || take;
            fft_on_q   <= (state_nx != FLUSH);
            underrun_q <= abort || (run_slot && !bus.s_valid);
            if ((accept_idle || run_slot) && bus.s_valid) begin
                fft_re_q <= bus.s_re;
                fft_im_q <= bus.s_im;
            end else begin
                fft_re_q <= '0;
                fft_im_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 pend <= '0;
        else if (abort)                             pend <= '0;
        else if (frame_done && !(out_fire && out_last)) pend <= pend + 2'd1;
        else if (!frame_done && out_fire && out_last)   pend <= pend - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt     <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            m_index_q   <= '0;
            m_re_q      <= '0;
            m_im_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            m_valid_q <= out_fire;
            m_sof_q   <= out_fire && (out_cnt == '0);
            m_eof_q   <= out_fire && out_last;
            if (out_fire) begin
                m_index_q <= out_cnt;
                m_re_q    <= bus.fft_do_re;
                m_im_q    <= bus.fft_do_im;
                out_cnt   <= out_cnt + 1'b1;
                if (out_last) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (state == FLUSH) out_cnt <= '0;
        end
    end

    assign bus.s_ready   = ((state == IDLE) && bus.enable) || run_slot;
    assign bus.fft_en    = fft_en_q;
    assign bus.fft_on    = fft_on_q;
    assign bus.fft_re    = fft_re_q;
    assign bus.fft_im    = fft_im_q;
    assign bus.underrun  = underrun_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_sof     = m_sof_q;
    assign bus.m_eof     = m_eof_q;
    assign bus.m_index   = m_index_q;
    assign bus.m_re      = m_re_q;
    assign bus.m_im      = m_im_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.busy      = (state != IDLE) || (pend != 2'd0);
endmodule
